aes_dec_feeder: RTL and testbench
=================================

Name: aes_dec_feeder

Overview:
- Word-serial front end for the inverse-cipher core, sitting between the 32-bit bus-side producer and the core.
- Assembles 32-bit words into 128-bit key or ciphertext blocks and sequences the core's kld/kdone and ld/done handshakes.
- Captures the core's plaintext into a one-entry output buffer with a valid/ready interface.
- Guarantees the core is never launched while its previous result is unconsumed.

Parameters:
- TIMEOUT_CYC, 64: maximum cycles to wait for core_done or core_kdone. Used only with AES_FEED_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- s_valid  in  1  input word valid
- s_ready  out  1  input word accepted when s_valid && s_ready
- s_key  in  1  group type, sampled on word 0 only: 1=key, 0=ciphertext
- s_data  in  32  input word; word 0 maps to bits [127:96], word 3 to [31:0]
- core_kld  out  1  one-cycle key-load pulse to core
- core_key  out  128  key to core; registered, held stable between loads
- core_ld  out  1  one-cycle block-load pulse to core
- core_text_in  out  128  ciphertext to core; held stable from core_ld until core_done
- core_kdone  in  1  core key-expansion done pulse
- core_done  in  1  core block done pulse
- core_text_out  in  128  core plaintext, valid in the core_done cycle
- m_valid  out  1  output block valid
- m_ready  in  1  output consumer ready
- m_data  out  128  plaintext block
- busy  out  1  high whenever state != COLLECT
- err_nokey  out  1  sticky: a ciphertext group arrived with no key loaded
- err_clr  in  1  clears the sticky error flags

Behaviour:
- Reset values:
  - All outputs 0; state=COLLECT; wcnt=0; key_ok=0.
  - core_key, core_text_in, m_data are 0.
  - Reset mid-operation abandons the group in flight and clears key_ok, so a new key load is required.
- COLLECT:
  - s_ready=1.
  - On each accept, shift s_data into the assembly register and increment the 2-bit wcnt.
  - Latch s_key into grp_key at wcnt=0.
  - The accept at wcnt=3 wraps wcnt to 0 and transitions the next cycle:
    - grp_key=1: go to KEY_LD.
    - grp_key=0 and key_ok=1: go to TXT_LD.
    - grp_key=0 and key_ok=0: set err_nokey, drop the group, stay in COLLECT.
- KEY_LD:
  - core_key <= assembly; core_kld=1 for exactly one cycle; key_ok <= 0.
  - Go to KEY_WAIT.
- KEY_WAIT:
  - On core_kdone: key_ok <= 1, go to COLLECT.
- TXT_LD:
  - Entered with core_text_in <= assembly.
  - Asserts core_ld=1 for one cycle only when the output buffer will be free: m_valid==0, or (m_valid && m_ready) this cycle.
  - Otherwise stays in TXT_LD with core_ld=0.
  - After the pulse, go to TXT_WAIT.
- TXT_WAIT:
  - On core_done: m_data <= core_text_out, m_valid <= 1, go to COLLECT.
- Output buffer:
  - m_valid clears on m_valid && m_ready.
  - A same-cycle clear and set (core_done) results in set.
- Core pulses:
  - core_done and core_kdone are ignored outside their WAIT states.
- Latency:
  - Last input word to core_ld is 2 cycles when the buffer is free.
  - core_done to m_valid is 1 cycle.
- s_ready=0 in every state except COLLECT; the next group cannot start until the core finishes.
- err_clr:
  - Clears err_nokey (and err_timeout) next cycle.
  - A set in the same cycle as err_clr wins.

Optional Feature:
- Macro: AES_FEED_TIMEOUT_EN.
- Defined:
  - Adds output err_timeout (1 bit, sticky, cleared by err_clr).
  - Adds a wait counter, reset to 0 on entry to KEY_WAIT or TXT_WAIT.
  - If the counter reaches TIMEOUT_CYC without the expected pulse: set err_timeout, clear key_ok, return to COLLECT, produce no output.
- Undefined:
  - No port and no counter; the WAIT states wait indefinitely.

Decomposition:
- Package aes_feed_pkg holds:
  - state enum feed_state_t (COLLECT, KEY_LD, KEY_WAIT, TXT_LD, TXT_WAIT);
  - localparams BLK_W=128, WORD_W=32, WORDS_PER_BLK=4.
- One natural sub-module, aes_word_packer: the 32→128 shift register plus wcnt and grp_key latch, exposing a blk_full pulse.
- The FSM and output buffer stay in aes_dec_feeder.

Test Plan:
- Key load: words 2b7e1516, 28aed2a6, abf71588, 09cf4f3c with s_key=1.
  -> core_key=2b7e151628aed2a6abf7158809cf4f3c; core_kld high exactly 1 cycle.
  -> busy held until core_kdone.
- Decrypt with the real core: after the key load, send ciphertext 3925841d 02dc09fb dc118597 196a0b32.
  -> core_ld 2 cycles after the last word.
  -> m_valid with m_data=3243f6a8885a308d313198a2e0370734.
- No key: send a ciphertext group after reset.
  -> err_nokey=1; no core_ld pulse; s_ready stays 1.
  -> err_clr=1 for 1 cycle clears err_nokey.
- Backpressure: m_ready=0 while holding result 1, then send block 2.
  -> Stays in TXT_LD with core_ld=0.
  -> core_ld fires in the cycle m_ready rises; m_data later shows block 2.
- Reset mid-TXT_WAIT: assert rst for 1 cycle.
  -> All outputs 0; key_ok=0; a subsequent ciphertext group sets err_nokey.
- With AES_FEED_TIMEOUT_EN and TIMEOUT_CYC=8: a stub core never pulses core_done.
  -> err_timeout=1 after 8 cycles; state returns to COLLECT; m_valid stays 0.

Source files
------------

// File: rtl/aes_feed_pkg.sv
// Shared types and sizes for the AES decrypt word feeder.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package aes_feed_pkg;
   localparam int BLK_W         = 128;
   localparam int WORD_W        = 32;
   localparam int WORDS_PER_BLK = 4;

   typedef enum logic [2:0] {
      COLLECT,
      KEY_LD,
      KEY_WAIT,
      TXT_LD,
      TXT_WAIT
   } feed_state_t;
endpackage

// File: rtl/aes_dec_feeder_if.sv
// Bus-side word input stream and plaintext block output stream of the feeder.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both streams; the slave side is the feeder.
interface aes_dec_feeder_if;
   import aes_feed_pkg::*;

   logic              s_valid;
   logic              s_ready;
   logic              s_key;
   logic [WORD_W-1:0] s_data;
   logic              m_valid;
   logic              m_ready;
   logic [BLK_W-1:0]  m_data;

   modport slave (
      input  s_valid, s_key, s_data, m_ready,
      output s_ready, m_valid, m_data
   );

   modport master (
      output s_valid, s_key, s_data, m_ready,
      input  s_ready, m_valid, m_data
   );
endinterface

// File: rtl/aes_word_packer.sv
// Packs four 32-bit words (first word lands in the MSBs) into a 128-bit block.
// Latency: blk_full_o pulses the cycle after the fourth accepted word.
// Backpressure: none of its own; the caller gates acc_i with its ready.
module aes_word_packer
   import aes_feed_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              acc_i,
   input  logic              key_i,
   input  logic [WORD_W-1:0] data_i,
   output logic [BLK_W-1:0]  blk_o,
   output logic              grp_key_o,
   output logic              blk_full_o
);
   logic [1:0]       wcnt_q;
   logic [BLK_W-1:0] asm_q;
   logic             grp_key_q;
   logic             blk_full_q;

   // Shift accepted words in, count them and latch the group type on word 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt_q     <= '0;
         asm_q      <= '0;
         grp_key_q  <= 1'b0;
         blk_full_q <= 1'b0;
      end else begin
         blk_full_q <= 1'b0;
         if (acc_i) begin
            asm_q  <= {asm_q[BLK_W-WORD_W-1:0], data_i};
            wcnt_q <= wcnt_q + 2'd1;
            if (wcnt_q == 2'd0)
               grp_key_q <= key_i;
            if (wcnt_q == 2'(WORDS_PER_BLK - 1))
               blk_full_q <= 1'b1;
         end
      end
   end

   assign blk_o      = asm_q;
   assign grp_key_o  = grp_key_q;
   assign blk_full_o = blk_full_q;
endmodule

// File: rtl/aes_dec_feeder.sv
// Word-serial front end that loads keys/ciphertext into the inverse-cipher core and buffers plaintext.
// Latency: last word to core_ld 2 cycles (buffer free); core_done to m_valid 1 cycle.
// Backpressure: s_ready only in COLLECT; core_ld held off while the one-entry output buffer stays full.
// Optional AES_FEED_TIMEOUT_EN adds err_timeout and a TIMEOUT_CYC watchdog on both core waits.
module aes_dec_feeder
   import aes_feed_pkg::*;
#(
   parameter int TIMEOUT_CYC = 64
)
(
   input  logic             clk,
   input  logic             rst,
   aes_dec_feeder_if.slave  bus,
   output logic             core_kld,
   output logic [BLK_W-1:0] core_key,
   output logic             core_ld,
   output logic [BLK_W-1:0] core_text_in,
   input  logic             core_kdone,
   input  logic             core_done,
   input  logic [BLK_W-1:0] core_text_out,
   output logic             busy,
   output logic             err_nokey,
`ifdef AES_FEED_TIMEOUT_EN
   output logic             err_timeout,
`endif
   input  logic             err_clr
);
   feed_state_t      state_q;
   logic             key_ok_q;
   logic             m_valid_q;
   logic             err_nokey_q;
   logic [BLK_W-1:0] core_key_q;
   logic [BLK_W-1:0] core_text_q;
   logic [BLK_W-1:0] m_data_q;

   logic             acc;
   logic             blk_full;
   logic             grp_key;
   logic [BLK_W-1:0] blk;
   logic             buf_free;
   logic             tmo_hit;

   assign bus.s_ready = (state_q == COLLECT) && !rst;
   assign acc         = bus.s_valid && bus.s_ready;
   // Launch only when the core's result is guaranteed a slot in the output buffer.
   assign buf_free    = !m_valid_q || bus.m_ready;

   aes_word_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .acc_i      (acc),
      .key_i      (bus.s_key),
      .data_i     (bus.s_data),
      .blk_o      (blk),
      .grp_key_o  (grp_key),
      .blk_full_o (blk_full)
   );

`ifdef AES_FEED_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] tmo_q;
   logic             err_timeout_q;
   logic             in_wait;
   logic             tmo_set;

   assign in_wait = (state_q == KEY_WAIT) || (state_q == TXT_WAIT);
   assign tmo_hit = in_wait && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
   assign tmo_set = tmo_hit && !((state_q == KEY_WAIT && core_kdone) ||
                                 (state_q == TXT_WAIT && core_done));

   // Count cycles spent in a wait state; zero everywhere else so each entry starts fresh.
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_q         <= '0;
         err_timeout_q <= 1'b0;
      end else begin
         tmo_q <= in_wait ? tmo_q + 1'b1 : '0;
         if (tmo_set)
            err_timeout_q <= 1'b1;
         else if (err_clr)
            err_timeout_q <= 1'b0;
      end
   end

   assign err_timeout = err_timeout_q;
`else
   assign tmo_hit = 1'b0;
`endif

   // Main sequencer: group dispatch, core handshakes, output buffer and sticky error.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= COLLECT;
         key_ok_q    <= 1'b0;
         m_valid_q   <= 1'b0;
         err_nokey_q <= 1'b0;
         core_key_q  <= '0;
         core_text_q <= '0;
         m_data_q    <= '0;
      end else begin
         if (err_clr)
            err_nokey_q <= 1'b0;
         if (m_valid_q && bus.m_ready)
            m_valid_q <= 1'b0;
         case (state_q)
            COLLECT: begin
               if (blk_full) begin
                  if (grp_key) begin
                     // Key is presented during the kld cycle, so load it on entry.
                     core_key_q <= blk;
                     key_ok_q   <= 1'b0;
                     state_q    <= KEY_LD;
                  end else if (key_ok_q) begin
                     core_text_q <= blk;
                     state_q     <= TXT_LD;
                  end else begin
                     err_nokey_q <= 1'b1;
                  end
               end
            end
            KEY_LD:  state_q <= KEY_WAIT;
            KEY_WAIT: begin
               if (core_kdone) begin
                  key_ok_q <= 1'b1;
                  state_q  <= COLLECT;
               end else if (tmo_hit) begin
                  key_ok_q <= 1'b0;
                  state_q  <= COLLECT;
               end
            end
            TXT_LD: begin
               if (buf_free)
                  state_q <= TXT_WAIT;
            end
            TXT_WAIT: begin
               if (core_done) begin
                  m_data_q  <= core_text_out;
                  m_valid_q <= 1'b1;
                  state_q   <= COLLECT;
               end else if (tmo_hit) begin
                  key_ok_q <= 1'b0;
                  state_q  <= COLLECT;
               end
            end
            default: state_q <= COLLECT;
         endcase
      end
   end

   assign core_kld     = (state_q == KEY_LD);
   assign core_ld      = (state_q == TXT_LD) && buf_free;
   assign core_key     = core_key_q;
   assign core_text_in = core_text_q;
   assign busy         = (state_q != COLLECT);
   assign err_nokey    = err_nokey_q;
   assign bus.m_valid  = m_valid_q;
   assign bus.m_data   = m_data_q;
endmodule

// File: tb/tb_aes_dec_feeder.sv
// Directed-plus-random bench for aes_dec_feeder with a behavioural core stub.
// Latency: n/a.
// Backpressure: exercised through m_ready holds.
module tb_aes_dec_feeder;
   import aes_feed_pkg::*;

   localparam int TMO = 8;
   localparam logic [127:0] K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] C = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] P = 128'h3243f6a8885a308d313198a2e0370734;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   aes_dec_feeder_if bus();
   logic         core_kld, core_ld, core_kdone, core_done, busy, err_nokey, err_clr;
   logic [127:0] core_key, core_text_in, core_text_out;
`ifdef AES_FEED_TIMEOUT_EN
   logic         err_timeout;
`endif

   aes_dec_feeder #(.TIMEOUT_CYC(TMO)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .core_kld      (core_kld),
      .core_key      (core_key),
      .core_ld       (core_ld),
      .core_text_in  (core_text_in),
      .core_kdone    (core_kdone),
      .core_done     (core_done),
      .core_text_out (core_text_out),
      .busy          (busy),
      .err_nokey     (err_nokey),
`ifdef AES_FEED_TIMEOUT_EN
      .err_timeout   (err_timeout),
`endif
      .err_clr       (err_clr)
   );

   int n_pass = 0, n_fail = 0, n_total = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural stand-in for the inverse cipher: the real FIPS-197 vector, otherwise a keyed mix.
   function automatic logic [127:0] ref_dec(input logic [127:0] k, input logic [127:0] c);
      if (k == K && c == C) return P;
      return c ^ {k[63:0], k[127:64]} ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
   endfunction

   // Core stub: answers kld/ld after a programmable delay, can be muted or flushed.
   int kdly = 2, ddly = 2, kcnt = 0, dcnt = 0;
   bit mute = 0, flush = 0, kpend = 0, dpend = 0;
   int n_kld = 0, n_ld = 0, ld_cyc = -1, kdone_cyc = -1;
   logic [127:0] seen_key = '0, seen_ct = '0;
   always @(negedge clk) begin
      core_kdone = 1'b0;
      core_done  = 1'b0;
      if (rst || flush) begin
         kpend = 0;
         dpend = 0;
      end else begin
         if (core_kld) begin
            n_kld++; seen_key = core_key; kpend = 1; kcnt = kdly;
         end else if (kpend && !mute) begin
            if (kcnt == 0) begin core_kdone = 1'b1; kpend = 0; kdone_cyc = cyc; end
            else kcnt--;
         end
         if (core_ld) begin
            n_ld++; ld_cyc = cyc; seen_ct = core_text_in; dpend = 1; dcnt = ddly;
         end else if (dpend && !mute) begin
            if (dcnt == 0) begin
               core_done = 1'b1; core_text_out = ref_dec(seen_key, seen_ct); dpend = 0;
            end else dcnt--;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Sends one 4-word group; returns the cycle index in which the last word was presented.
   task automatic send_group(input bit key, input logic [127:0] blk, output int last_cyc);
      last_cyc = -1;
      for (int i = 0; i < 4; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            bus.s_valid = 1'b0;
            tick();
         end
         bus.s_valid = 1'b1;
         bus.s_key   = (i == 0) ? key : 1'($urandom_range(0, 1));
         bus.s_data  = blk[127-32*i -: 32];
         for (int w = 0; w < 50 && !bus.s_ready; w++) tick();
         chk("s_ready_wait", bus.s_ready, 1);
         last_cyc = cyc;
         tick();
      end
      bus.s_valid = 1'b0;
   endtask

   task automatic wait_mvalid(input string tag);
      for (int w = 0; w < 100 && !bus.m_valid; w++) tick();
      chk(tag, bus.m_valid, 1);
   endtask

   task automatic consume();
      bus.m_ready = 1'b1;
      tick();
      bus.m_ready = 1'b0;
      chk("m_valid_clr", bus.m_valid, 0);
   endtask

   task automatic load_key(input logic [127:0] k);
      int lw, k0;
      k0 = n_kld;
      send_group(1'b1, k, lw);
      tick();
      chk("key_busy", busy, 1);
      for (int w = 0; w < 100 && busy; w++) tick();
      chk("key_kld_once", n_kld - k0, 1);
      chk("key_core_key", core_key, k);
      chk("key_busy_until_kdone", cyc, kdone_cyc + 1);
   endtask

   initial begin
      int lw, n0, t0;
      logic [127:0] ct, a, b;
      rst = 1'b1; err_clr = 1'b0;
      bus.s_valid = 1'b0; bus.s_key = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
      core_kdone = 1'b0; core_done = 1'b0; core_text_out = '0;
      tick(); tick();
      chk("rst_flags", {bus.s_ready, busy, core_kld, core_ld, bus.m_valid, err_nokey}, 0);
      chk("rst_core_key", core_key, 0);
      chk("rst_text_in", core_text_in, 0);
      chk("rst_m_data", bus.m_data, 0);
      rst = 1'b0;
      tick();
      chk("idle_s_ready", bus.s_ready, 1);

      // Ciphertext with no key loaded: flagged, dropped, no launch.
      n0 = n_ld;
      send_group(1'b0, {$urandom, $urandom, $urandom, $urandom}, lw);
      tick(); tick();
      chk("nokey_err", err_nokey, 1);
      chk("nokey_no_ld", n_ld - n0, 0);
      chk("nokey_s_ready", bus.s_ready, 1);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("nokey_clr", err_nokey, 0);

      // Key load then the reference ciphertext.
      kdly = 3;
      load_key(K);
      ddly = 4;
      send_group(1'b0, C, lw);
      wait_mvalid("vec_m_valid");
      chk("vec_ld_lat", ld_cyc, lw + 2);
      chk("vec_text_in", seen_ct, C);
      chk("vec_m_data", bus.m_data, P);
      consume();

      // Random ciphertext blocks against the reference model.
      for (int i = 0; i < 6; i++) begin
         ct   = {$urandom, $urandom, $urandom, $urandom};
         ddly = $urandom_range(0, 5);
         send_group(1'b0, ct, lw);
         wait_mvalid("rnd_m_valid");
         chk("rnd_ld_lat", ld_cyc, lw + 2);
         chk("rnd_m_data", bus.m_data, ref_dec(K, ct));
         for (int w = $urandom_range(0, 3); w > 0; w--) tick();
         consume();
      end

      // Backpressure: result A held, block B must wait in the load state.
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      ddly = 1;
      send_group(1'b0, a, lw);
      wait_mvalid("bp_a_valid");
      n0 = n_ld;
      send_group(1'b0, b, lw);
      tick(); tick(); tick(); tick();
      chk("bp_stall_no_ld", {n_ld - n0, core_ld}, 0);
      chk("bp_stall_state", {busy, bus.s_ready}, 2'b10);
      chk("bp_text_in", core_text_in, b);
      bus.m_ready = 1'b1;
      #1;
      chk("bp_ld_on_ready", core_ld, 1);
      chk("bp_a_data", bus.m_data, ref_dec(K, a));
      tick();
      bus.m_ready = 1'b0;
      chk("bp_a_gone", bus.m_valid, 0);
      wait_mvalid("bp_b_valid");
      chk("bp_b_data", bus.m_data, ref_dec(K, b));
      consume();

      // Reset while the core is working: everything clears and the key is forgotten.
      ddly = 20;
      n0 = n_ld;
      send_group(1'b0, {$urandom, $urandom, $urandom, $urandom}, lw);
      for (int w = 0; w < 50 && n_ld == n0; w++) tick();
      chk("mid_ld_seen", n_ld - n0, 1);
      tick(); tick();
      rst = 1'b1; tick();
      chk("mid_rst_flags", {bus.s_ready, busy, core_kld, core_ld, bus.m_valid, err_nokey}, 0);
      chk("mid_rst_vals", {core_key ^ core_text_in, bus.m_data}, 0);
      rst = 1'b0; tick();
      n0 = n_ld;
      err_clr = 1'b1;
      send_group(1'b0, {$urandom, $urandom, $urandom, $urandom}, lw);
      tick();
      err_clr = 1'b0;
      chk("mid_nokey_set_wins", err_nokey, 1);
      chk("mid_no_ld", n_ld - n0, 0);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("mid_clr", err_nokey, 0);

`ifdef AES_FEED_TIMEOUT_EN
      // Silent core: watchdog returns to idle, flags, drops the key.
      kdly = 1; ddly = 1;
      load_key(K);
      mute = 1;
      n0 = n_ld;
      send_group(1'b0, C, lw);
      for (int w = 0; w < 50 && n_ld == n0; w++) tick();
      t0 = -1;
      for (int w = 0; w < 50 && !err_timeout; w++) tick();
      if (err_timeout) t0 = cyc;
      chk("tmo_cycle", t0, ld_cyc + 1 + TMO);
      chk("tmo_idle", {busy, bus.m_valid}, 0);
      flush = 1; tick(); flush = 0; mute = 0;
      send_group(1'b0, C, lw);
      tick(); tick();
      chk("tmo_key_lost", err_nokey, 1);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("tmo_clr", {err_timeout, err_nokey}, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
      $fatal(1, "watchdog");
   end
endmodule
